// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, controller states and ALU select encodings
// The ALU-control decoder shares the source and aluop encodings defined here.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
      WB_ALU, WB_MEM, BRANCH, HALT
   } state_e;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;

   localparam logic [1:0] SRC_B_RS2   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_wait.sv
// rtl/multicycle_ctrl_wait.sv - memory wait counter with bus-error timeout
// timeout_o fires on the WAIT_LIMIT-th unacknowledged cycle; an acknowledge on that cycle wins.
module multicycle_ctrl_wait #(
   parameter int unsigned WAIT_LIMIT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stall;

   assign stall = req_i && !ready_i;

   always_comb begin
      cnt_d = '0;
      if (stall) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign timeout_o = (WAIT_LIMIT != 0) && stall && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32 subset main controller
// MULTICYCLE_CTRL_PERF_EN adds the cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 0
`ifdef MULTICYCLE_CTRL_PERF_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] aluop,
   output logic       regwrite,
   output logic       memtoreg,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
   , output logic [CNT_W-1:0] cycle_cnt
   , output logic [CNT_W-1:0] instret_cnt
`endif
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   bus_err_q, bus_err_d;
   logic   fetch_pend_q, fetch_pend_d;
   logic   req, ack, timeout, mem_state;

   // A fetch already on the bus stays requested even if run drops.
   assign mem_state = (state_q == MEM_RD) || (state_q == MEM_WR);
   assign req       = (state_q == FETCH) ? (run || fetch_pend_q) : mem_state;
   assign ack       = req && mem_ready;

   assign mem_req = req && rst_n;
   assign mem_we  = (state_q == MEM_WR) && rst_n;
   assign iord    = mem_state && rst_n;
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

   multicycle_ctrl_wait #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .ready_i   (mem_ready),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         illegal_q    <= 1'b0;
         bus_err_q    <= 1'b0;
         fetch_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         illegal_q    <= illegal_d;
         bus_err_q    <= bus_err_d;
         fetch_pend_q <= fetch_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      bus_err_d    = bus_err_q;
      fetch_pend_d = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_src_a    = SRC_A_PC;
      alu_src_b    = SRC_B_RS2;
      aluop        = ALUOP_ADD;
      regwrite     = 1'b0;
      memtoreg     = 1'b0;
      retire       = 1'b0;
      case (state_q)
         FETCH: begin
            alu_src_b = SRC_B_FOUR;
            if (ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = HALT;
            end else begin
               fetch_pend_d = req;
            end
         end
         DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            case (opcode)
               OP_R:         state_d = EXEC_R;
               OP_ADDI:      state_d = EXEC_I;
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_BEQ:       state_d = BRANCH;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = HALT;
               end
            endcase
         end
         EXEC_R: begin
            alu_src_a = SRC_A_RS1;
            aluop     = ALUOP_FUNCT;
            state_d   = WB_ALU;
         end
         EXEC_I: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = WB_ALU;
         end
         MEM_ADDR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            if (ack) state_d = WB_MEM;
            else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = HALT;
            end
         end
         MEM_WR: begin
            if (ack) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = HALT;
            end
         end
         WB_ALU: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         WB_MEM: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            alu_src_a = SRC_A_RS1;
            aluop     = ALUOP_SUB;
            pc_write  = zero;
            pc_src    = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = HALT;
      endcase
      // Outputs go quiet the moment reset asserts, not at the next edge.
      if (!rst_n) begin
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         pc_src    = 1'b0;
         alu_src_a = 2'b00;
         alu_src_b = 2'b00;
         aluop     = 2'b00;
         regwrite  = 1'b0;
         memtoreg  = 1'b0;
         retire    = 1'b0;
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [CNT_W-1:0] cycle_q, instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else if (state_q != HALT) begin
         cycle_q <= cycle_q + CNT_W'(1);
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`endif

endmodule
